// File: rtl/pim_burst_dma.sv
// Burst DMA engine between system memory and the PIM macro. Words move through a BURST_LEN-deep buffer.
// Define PIM_DMA_IRQ_EN to add the sticky o_irq flag and its i_irq_clr input.
module pim_burst_dma #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int CNT_W     = 13,
  parameter int SEL_W     = 4,
  parameter int BURST_LEN = 4,
  parameter logic [AW-1:0] PIM_CTRL         = 32'h4000_0010,
  parameter logic [AW-1:0] PIM_R            = 32'h4000_0020,
  parameter logic [AW-1:0] PIM_W_WEIGHT     = 32'h4000_0040,
  parameter logic [AW-1:0] PIM_W_ACTIVATION = 32'h4000_0080
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_dma_en,
  input  logic [2:0]       i_funct3,
  input  logic [SEL_W-1:0] i_sel_pim,
  input  logic [CNT_W-1:0] i_size,
  input  logic [AW-1:0]    i_mem_addr,
  output logic             o_bus_req,
  input  logic             i_bus_gnt,
  output logic [AW-1:0]    o_dma_addr,
  output logic             o_dma_write,
  output logic             o_dma_read,
  output logic [DW/8-1:0]  o_dma_size,
  output logic [DW-1:0]    o_dma_wr_data,
  input  logic [DW-1:0]    i_dma_rd_data,
  output logic             o_dma_busy,
  output logic             o_dma_done,
  output logic             o_dma_err
`ifdef PIM_DMA_IRQ_EN
  ,
  output logic             o_irq,
  input  logic             i_irq_clr
`endif
);

  localparam int BYTES = DW / 8;
  localparam int BW    = $clog2(BURST_LEN + 1);
  localparam int IW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_POLL = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [2:0] F_WEIGHT = 3'b001;
  localparam logic [2:0] F_ACT    = 3'b010;
  localparam logic [2:0] F_LOAD   = 3'b100;

  logic [2:0]       r_state;
  logic [2:0]       r_funct3;
  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_remaining;
  logic [AW-1:0]    r_mem_addr;
  logic [BW-1:0]    r_burst;
  logic [BW-1:0]    r_rd_idx;
  logic [BW-1:0]    r_wr_idx;
  logic [DW-1:0]    r_buf [BURST_LEN];

  logic             w_load;
  logic             w_start_ok;
  logic             w_poll_ok;
  logic             w_rd_last;
  logic             w_wr_last;
  logic [AW-1:0]    w_pim_waddr;
  logic [BW-1:0]    w_burst_next;
  logic [CNT_W-1:0] w_rem_next;

  assign w_load       = (r_funct3 == F_LOAD);
  assign w_start_ok   = (i_size != '0) &&
                        ((i_funct3 == F_WEIGHT) || (i_funct3 == F_ACT) || (i_funct3 == F_LOAD));
  assign w_poll_ok    = !i_dma_rd_data[0] && (!w_load || i_dma_rd_data[1]);
  assign w_rd_last    = (r_rd_idx == (r_burst - BW'(1)));
  assign w_wr_last    = (r_wr_idx == (r_burst - BW'(1)));
  assign w_pim_waddr  = ((r_funct3 == F_WEIGHT) ? PIM_W_WEIGHT : PIM_W_ACTIVATION) | AW'(r_sel);
  assign w_burst_next = (r_remaining >= CNT_W'(BURST_LEN)) ? BW'(BURST_LEN) : BW'(r_remaining);
  assign w_rem_next   = r_remaining - CNT_W'(r_burst);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_funct3    <= '0;
      r_sel       <= '0;
      r_remaining <= '0;
      r_mem_addr  <= '0;
      r_burst     <= '0;
      r_rd_idx    <= '0;
      r_wr_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_dma_en) begin
            r_funct3    <= i_funct3;
            r_sel       <= i_sel_pim;
            r_remaining <= i_size;
            r_mem_addr  <= i_mem_addr;
            r_state     <= w_start_ok ? S_POLL : S_ERR;
          end
        end
        S_POLL: begin
          if (i_bus_gnt && w_poll_ok) begin
            r_burst  <= w_burst_next;
            r_rd_idx <= '0;
            r_state  <= S_RD;
          end
        end
        S_RD: begin
          if (i_bus_gnt) begin
            if (!w_load) r_mem_addr <= r_mem_addr + AW'(BYTES);
            if (w_rd_last) begin
              r_rd_idx <= '0;
              r_wr_idx <= '0;
              r_state  <= S_WR;
            end else begin
              r_rd_idx <= r_rd_idx + BW'(1);
            end
          end
        end
        S_WR: begin
          if (i_bus_gnt) begin
            if (w_load) r_mem_addr <= r_mem_addr + AW'(BYTES);
            if (w_wr_last) begin
              r_wr_idx    <= '0;
              r_remaining <= w_rem_next;
              r_state     <= (w_rem_next == '0) ? S_DONE : S_POLL;
            end else begin
              r_wr_idx <= r_wr_idx + BW'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer is pure storage; its contents are only ever observed after being refilled by RD.
  always_ff @(posedge i_clk) begin
    if (r_state == S_RD && i_bus_gnt) r_buf[r_rd_idx[IW-1:0]] <= i_dma_rd_data;
  end

  always_comb begin
    o_bus_req     = (r_state == S_POLL) || (r_state == S_RD) || (r_state == S_WR);
    o_dma_busy    = o_bus_req || (r_state == S_DONE);
    o_dma_done    = (r_state == S_DONE);
    o_dma_err     = (r_state == S_ERR);
    o_dma_addr    = '0;
    o_dma_read    = 1'b0;
    o_dma_write   = 1'b0;
    o_dma_size    = '0;
    o_dma_wr_data = '0;
    if (i_bus_gnt) begin
      case (r_state)
        S_POLL: begin
          o_dma_addr = PIM_CTRL;
          o_dma_read = 1'b1;
          o_dma_size = '1;
        end
        S_RD: begin
          o_dma_addr = w_load ? PIM_R : r_mem_addr;
          o_dma_read = 1'b1;
          o_dma_size = '1;
        end
        S_WR: begin
          o_dma_addr    = w_load ? r_mem_addr : w_pim_waddr;
          o_dma_write   = 1'b1;
          o_dma_size    = '1;
          o_dma_wr_data = r_buf[r_wr_idx[IW-1:0]];
        end
        default: ;
      endcase
    end
  end

`ifdef PIM_DMA_IRQ_EN
  logic r_irq;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                  r_irq <= 1'b0;
    else if (r_state == S_DONE || r_state == S_ERR) r_irq <= 1'b1;
    else if (i_irq_clr)                            r_irq <= 1'b0;
  end

  assign o_irq = r_irq;
`endif

endmodule

// File: tb/tb_pim_burst_dma.sv
// Directed self-checking bench for pim_burst_dma: a bus monitor logs every access and
// each test compares the log against hand-derived transaction sequences.
module tb_pim_burst_dma;

  localparam logic [31:0] CTRL = 32'h4000_0010;
  localparam logic [31:0] PIMR = 32'h4000_0020;

  logic        clock;
  logic        rstN;
  logic        dmaEn;
  logic [2:0]  funct3;
  logic [3:0]  selPim;
  logic [12:0] size;
  logic [31:0] memAddr;
  logic        busReq;
  logic        gnt;
  logic [31:0] dmaAddr;
  logic        dmaWrite;
  logic        dmaRead;
  logic [3:0]  dmaSize;
  logic [31:0] dmaWrData;
  logic [31:0] rdData;
  logic        dmaBusy;
  logic        dmaDone;
  logic        dmaErr;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [31:0] pollCnt   = 0;
  logic [31:0] resultCnt = 0;
  logic [31:0] pollBase, resultBase;
  logic [1:0]  statusSeq [8];
  int          statusLen;
  logic [1:0]  statusBits;

  logic        logWrite [256];
  logic [31:0] logAddr  [256];
  logic [31:0] logData  [256];
  int logN = 0, doneCnt = 0, errCnt = 0, busyCnt = 0, sizeBad = 0;
  int logBase, doneBase, errBase, busyBase;

  pim_burst_dma dut (
    .i_clk(clock), .i_rst_n(rstN), .i_dma_en(dmaEn), .i_funct3(funct3),
    .i_sel_pim(selPim), .i_size(size), .i_mem_addr(memAddr),
    .o_bus_req(busReq), .i_bus_gnt(gnt), .o_dma_addr(dmaAddr),
    .o_dma_write(dmaWrite), .o_dma_read(dmaRead), .o_dma_size(dmaSize),
    .o_dma_wr_data(dmaWrData), .i_dma_rd_data(rdData),
    .o_dma_busy(dmaBusy), .o_dma_done(dmaDone), .o_dma_err(dmaErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Bus slave model: PIM status from a per-test sequence, results count up, memory is a hash of address.
  always_comb begin
    statusBits = 2'b00;
    if ((pollCnt - pollBase) < 32'(statusLen)) statusBits = statusSeq[pollCnt - pollBase];
    if (dmaAddr == CTRL)      rdData = {30'd0, statusBits};
    else if (dmaAddr == PIMR) rdData = 32'hC0DE_0000 + (resultCnt - resultBase);
    else                      rdData = memData(dmaAddr);
  end

  always @(posedge clock) begin
    if (dmaRead && dmaAddr == CTRL) pollCnt <= pollCnt + 1;
    if (dmaRead && dmaAddr == PIMR) resultCnt <= resultCnt + 1;
  end

  always @(negedge clock) begin
    if (dmaRead || dmaWrite) begin
      logWrite[logN] = dmaWrite;
      logAddr[logN]  = dmaAddr;
      logData[logN]  = dmaWrite ? dmaWrData : rdData;
      logN++;
      if (dmaSize != 4'hF) sizeBad++;
    end else if (dmaSize != 4'h0) begin
      sizeBad++;
    end
    if (dmaDone) doneCnt++;
    if (dmaErr)  errCnt++;
    if (dmaBusy) busyCnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    logBase    = logN;
    doneBase   = doneCnt;
    errBase    = errCnt;
    busyBase   = busyCnt;
    pollBase   = pollCnt;
    resultBase = resultCnt;
    statusLen  = 0;
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [3:0] s, input logic [12:0] n,
                               input logic [31:0] a);
    @(negedge clock);
    funct3 = f; selPim = s; size = n; memAddr = a; dmaEn = 1'b1;
    @(negedge clock);
    dmaEn = 1'b0;
  endtask

  task automatic expectEntry(input string tag, input int k, input logic w, input logic [31:0] a,
                             input logic [31:0] d);
    checkOutput($sformatf("%s%0d_wr", tag, k), 64'(logWrite[logBase + k]), 64'(w));
    checkOutput($sformatf("%s%0d_addr", tag, k), 64'(logAddr[logBase + k]), 64'(a));
    checkOutput($sformatf("%s%0d_data", tag, k), 64'(logData[logBase + k]), 64'(d));
  endtask

  task automatic waitDone(input string tag, input int limit);
    int n = 0;
    while (doneCnt == doneBase && n < limit) begin
      @(negedge clock);
      n++;
    end
    checkOutput({tag, "done_seen"}, 64'(doneCnt - doneBase), 64'd1);
  endtask

  initial begin
    rstN = 1'b0; dmaEn = 1'b0; gnt = 1'b1; funct3 = '0; selPim = '0; size = '0; memAddr = '0;
    pollBase = 0; resultBase = 0; statusLen = 0;
    logBase = 0; doneBase = 0; errBase = 0; busyBase = 0;
    for (int i = 0; i < 8; i++) statusSeq[i] = 2'b00;
    repeat (2) @(negedge clock);
    checkOutput("rst_busy", 64'(dmaBusy), 64'd0);
    checkOutput("rst_req", 64'(busReq), 64'd0);
    checkOutput("rst_rd_wr", 64'({dmaRead, dmaWrite, dmaDone, dmaErr}), 64'd0);
    rstN = 1'b1;

    $display("[TB] weight write, 6 words");
    clearLog();
    applyStimulus(3'b001, 4'd3, 13'd6, 32'h1000_0000);
    waitDone("t1_", 60);
    repeat (2) @(negedge clock);
    expectEntry("t1_", 0, 1'b0, CTRL, 32'd0);
    for (int k = 0; k < 4; k++) begin
      expectEntry("t1_", 1 + k, 1'b0, 32'h1000_0000 + 32'(4 * k), memData(32'h1000_0000 + 32'(4 * k)));
      expectEntry("t1_", 5 + k, 1'b1, 32'h4000_0043, memData(32'h1000_0000 + 32'(4 * k)));
    end
    expectEntry("t1_", 9, 1'b0, CTRL, 32'd0);
    for (int k = 0; k < 2; k++) begin
      expectEntry("t1_", 10 + k, 1'b0, 32'h1000_0010 + 32'(4 * k), memData(32'h1000_0010 + 32'(4 * k)));
      expectEntry("t1_", 12 + k, 1'b1, 32'h4000_0043, memData(32'h1000_0010 + 32'(4 * k)));
    end
    checkOutput("t1_count", 64'(logN - logBase), 64'd14);
    checkOutput("t1_busy_cycles", 64'(busyCnt - busyBase), 64'd15);

    $display("[TB] load, 2 words, delayed data_valid");
    clearLog();
    statusSeq[0] = 2'b00; statusSeq[1] = 2'b00; statusSeq[2] = 2'b00; statusSeq[3] = 2'b10;
    statusLen = 4;
    applyStimulus(3'b100, 4'd0, 13'd2, 32'h2000_0000);
    waitDone("t2_", 60);
    for (int k = 0; k < 3; k++) expectEntry("t2_", k, 1'b0, CTRL, 32'd0);
    expectEntry("t2_", 3, 1'b0, CTRL, 32'd2);
    expectEntry("t2_", 4, 1'b0, PIMR, 32'hC0DE_0000);
    expectEntry("t2_", 5, 1'b0, PIMR, 32'hC0DE_0001);
    expectEntry("t2_", 6, 1'b1, 32'h2000_0000, 32'hC0DE_0000);
    expectEntry("t2_", 7, 1'b1, 32'h2000_0004, 32'hC0DE_0001);
    checkOutput("t2_count", 64'(logN - logBase), 64'd8);
    checkOutput("t2_polls", 64'(pollCnt - pollBase), 64'd4);

    $display("[TB] activation write, 3 words, grant dropped");
    clearLog();
    applyStimulus(3'b010, 4'd5, 13'd3, 32'h3000_0100);
    @(posedge clock);
    @(posedge clock);
    #1 gnt = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checkOutput($sformatf("t3_gntlow%0d_req", c), 64'(busReq), 64'd1);
      checkOutput($sformatf("t3_gntlow%0d_bus", c),
                  64'({dmaAddr, dmaRead, dmaWrite, dmaSize}) | 64'(dmaWrData), 64'd0);
      @(posedge clock);
      if (c == 1) #1 gnt = 1'b1;
    end
    waitDone("t3_", 60);
    expectEntry("t3_", 0, 1'b0, CTRL, 32'd0);
    for (int k = 0; k < 3; k++) begin
      expectEntry("t3_", 1 + k, 1'b0, 32'h3000_0100 + 32'(4 * k), memData(32'h3000_0100 + 32'(4 * k)));
      expectEntry("t3_", 4 + k, 1'b1, 32'h4000_0085, memData(32'h3000_0100 + 32'(4 * k)));
    end
    checkOutput("t3_count", 64'(logN - logBase), 64'd7);

    $display("[TB] zero size and illegal funct3");
    clearLog();
    applyStimulus(3'b001, 4'd1, 13'd0, 32'h1000_0000);
    checkOutput("t4_err", 64'(dmaErr), 64'd1);
    checkOutput("t4_busy", 64'(dmaBusy), 64'd0);
    @(negedge clock);
    checkOutput("t4_err_pulse", 64'(dmaErr), 64'd0);
    applyStimulus(3'b011, 4'd1, 13'd2, 32'h1000_0000);
    checkOutput("t4_err_f3", 64'(dmaErr), 64'd1);
    repeat (3) @(negedge clock);
    checkOutput("t4_err_count", 64'(errCnt - errBase), 64'd2);
    checkOutput("t4_no_bus", 64'(logN - logBase), 64'd0);

    $display("[TB] start ignored while busy");
    clearLog();
    applyStimulus(3'b001, 4'd1, 13'd2, 32'h1000_0200);
    @(posedge clock);
    #1 dmaEn = 1'b1; funct3 = 3'b100; selPim = 4'd7; size = 13'd5; memAddr = 32'h0000_0009;
    @(posedge clock);
    #1 dmaEn = 1'b0;
    waitDone("t5_", 60);
    repeat (5) @(negedge clock);
    expectEntry("t5_", 0, 1'b0, CTRL, 32'd0);
    for (int k = 0; k < 2; k++) begin
      expectEntry("t5_", 1 + k, 1'b0, 32'h1000_0200 + 32'(4 * k), memData(32'h1000_0200 + 32'(4 * k)));
      expectEntry("t5_", 3 + k, 1'b1, 32'h4000_0041, memData(32'h1000_0200 + 32'(4 * k)));
    end
    checkOutput("t5_count", 64'(logN - logBase), 64'd5);
    checkOutput("t5_idle", 64'(dmaBusy), 64'd0);

    $display("[TB] reset during write phase");
    clearLog();
    applyStimulus(3'b001, 4'd0, 13'd4, 32'h1000_0400);
    repeat (6) @(posedge clock);
    #1 rstN = 1'b0;
    #1;
    checkOutput("t6_rst_now", 64'({busReq, dmaBusy, dmaRead, dmaWrite, dmaDone, dmaErr}), 64'd0);
    @(negedge clock);
    checkOutput("t6_rst_bus", 64'({dmaAddr, dmaSize}) | 64'(dmaWrData), 64'd0);
    repeat (2) @(negedge clock);
    checkOutput("t6_count", 64'(logN - logBase), 64'd6);
    expectEntry("t6_", 5, 1'b1, 32'h4000_0040, memData(32'h1000_0400));
    rstN = 1'b1;
    clearLog();
    applyStimulus(3'b010, 4'd2, 13'd1, 32'h4444_0000);
    waitDone("t6b_", 40);
    expectEntry("t6b_", 0, 1'b0, CTRL, 32'd0);
    expectEntry("t6b_", 1, 1'b0, 32'h4444_0000, memData(32'h4444_0000));
    expectEntry("t6b_", 2, 1'b1, 32'h4000_0082, memData(32'h4444_0000));
    checkOutput("t6b_count", 64'(logN - logBase), 64'd3);

    checkOutput("byte_enables", 64'(sizeBad), 64'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
